// File: rtl/dekatron_step_driver.sv
// Dekatron drive emulation: turns step requests into two-phase G1/G2 guide pulses
// and tracks the glowing cathode as a one-hot bus with wrap carry and load support.
module dekatron_step_driver #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned INIT_POS     = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_request,
    input  logic       i_dec,
    input  logic       i_set,
    input  logic [9:0] i_set_value,
    output logic       o_ready,
    output logic       o_g1,
    output logic       o_g2,
    output logic [9:0] o_out,
    output logic       o_carry_out,
    output logic       o_set_err
);

    typedef enum logic [1:0] {
        IDLE,
        PHASE_A,
        PHASE_B,
        SETTLE
    } state_t;

    localparam logic [9:0] INIT_ONEHOT = 10'(1) << INIT_POS;
    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_dec;
    logic [9:0] r_out;
    logic       r_g1;
    logic       r_g2;
    logic       r_carry;
    logic       r_set_err;

    state_t     w_state_next;
    logic [7:0] w_cnt_next;
    logic       w_dec_next;
    logic [9:0] w_out_next;
    logic       w_g1_next;
    logic       w_g2_next;
    logic       w_carry_next;
    logic       w_set_err_next;
    logic [9:0] w_rot_inc;
    logic [9:0] w_rot_dec;

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    // Increment moves the glow toward bit 9, decrement toward bit 0, both circular.
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_rot
            assign w_rot_inc[gi] = r_out[(gi + 9) % 10];
            assign w_rot_dec[gi] = r_out[(gi + 1) % 10];
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_dec_next     = r_dec;
        w_out_next     = r_out;
        w_carry_next   = 1'b0;
        w_set_err_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_set) begin
                    if (is_onehot(i_set_value)) begin
                        w_out_next = i_set_value;
                    end else begin
                        w_set_err_next = 1'b1;
                    end
                end else if (i_request) begin
                    w_dec_next   = i_dec;
                    w_cnt_next   = 8'd0;
                    w_state_next = PHASE_A;
                end
            end
            PHASE_A: begin
                if (r_cnt == PULSE_LAST) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = PHASE_B;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            PHASE_B: begin
                if (r_cnt == PULSE_LAST) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = SETTLE;
                    w_out_next   = r_dec ? w_rot_dec : w_rot_inc;
                    w_carry_next = r_dec ? r_out[0] : r_out[9];
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            SETTLE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A corrupted position bus snaps back to the reset cathode.
        if (!is_onehot(r_out)) begin
            w_out_next = INIT_ONEHOT;
        end

        w_g1_next = ((w_state_next == PHASE_A) && !w_dec_next) ||
                    ((w_state_next == PHASE_B) &&  w_dec_next);
        w_g2_next = ((w_state_next == PHASE_A) &&  w_dec_next) ||
                    ((w_state_next == PHASE_B) && !w_dec_next);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_dec     <= 1'b0;
            r_out     <= INIT_ONEHOT;
            r_g1      <= 1'b0;
            r_g2      <= 1'b0;
            r_carry   <= 1'b0;
            r_set_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_dec     <= w_dec_next;
            r_out     <= w_out_next;
            r_g1      <= w_g1_next;
            r_g2      <= w_g2_next;
            r_carry   <= w_carry_next;
            r_set_err <= w_set_err_next;
        end
    end

    assign o_ready     = (r_state == IDLE);
    assign o_g1        = r_g1;
    assign o_g2        = r_g2;
    assign o_out       = r_out;
    assign o_carry_out = r_carry;
    assign o_set_err   = r_set_err;

endmodule
